// File: rtl/led_matrix_scan.sv
// led_matrix_scan: 6x6 LED matrix row-scan driver with per-row dead-time blanking.
// Define LED_SCAN_DOUBLE_BUFFER_EN for a double-buffered frame store swapped at frame wrap.
module led_matrix_scan #(
    parameter int ROW_CYCLES   = 2000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_x,
    input  logic [2:0] wr_y,
    input  logic       wr_data,
    input  logic       clear,
    input  logic       swap_req,
    output logic       swap_done,
    output logic       frame_start,
    output logic [5:0] row,
    output logic [5:0] col
);
    localparam int CMAX = ROW_CYCLES > BLANK_CYCLES ? ROW_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    typedef enum logic {BLANK, DRIVE} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    row_idx;
    logic [35:0]   back, front, back_nxt;
    logic [5:0]    wr_idx;
    logic          wr_ok, wrap;
    assign wr_ok  = wr_en && wr_x < 3'd6 && wr_y < 3'd6;
    assign wr_idx = 6'(wr_y) * 6'd6 + 6'(wr_x);
    assign wrap   = state == DRIVE && cnt == CW'(ROW_CYCLES - 1) && row_idx == 3'd5;
    // clear is applied before the write so a same-cycle write survives
    always_comb begin
        back_nxt = clear ? '0 : back;
        if (wr_ok) back_nxt[wr_idx] = wr_data;
    end
`ifdef LED_SCAN_DOUBLE_BUFFER_EN
    logic swap_pend;
    // front takes the old back; back already equals the new front, so it keeps its contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            back      <= '0;
            front     <= '0;
            swap_pend <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            back      <= back_nxt;
            swap_done <= wrap && swap_pend;
            if (wrap && swap_pend) begin
                front     <= back;
                swap_pend <= swap_req;
            end else begin
                swap_pend <= swap_pend | swap_req;
            end
        end
    end
`else
    logic unused_swap_req;
    assign unused_swap_req = swap_req;
    assign front           = back;
    assign swap_done       = 1'b0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) back <= '0;
        else back <= back_nxt;
    end
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BLANK;
            cnt         <= '0;
            row_idx     <= 3'd0;
            row         <= 6'd0;
            col         <= 6'h3f;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (state == BLANK) begin
                if (cnt == CW'(BLANK_CYCLES - 1)) begin
                    state <= DRIVE;
                    cnt   <= '0;
                    row   <= 6'd1 << row_idx;
                    col   <= ~front[6'(row_idx) * 6'd6 +: 6];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (cnt == CW'(ROW_CYCLES - 1)) begin
                state   <= BLANK;
                cnt     <= '0;
                row     <= 6'd0;
                col     <= 6'h3f;
                row_idx <= row_idx == 3'd5 ? 3'd0 : row_idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Row-multiplexed refresh driver for the 6x6 LED FeatherWing matrix. It sits directly downstream of the snake game logic. The game writes individual pixels into an internal frame buffer, and this block time-multiplexes that buffer onto the `row`/`col` pins with a dead-time blank between rows. An optional double buffer gives tear-free frame updates.

## Interface
Parameters:
- `ROW_CYCLES`, default 2000: clock cycles each row is driven; must be >= 1.
- `BLANK_CYCLES`, default 16: all-off dead time before each row, to prevent ghosting; must be >= 1.

Ports:
- `clk` input 1: system clock. One clock domain only. Reset is asynchronous and active-low.
- `rst_n` input 1: asynchronous active-low reset.
- `wr_en` input 1: pixel write strobe.
- `wr_x` input 3: column 0..5; (0,0) is the top-left pixel.
- `wr_y` input 3: row 0..5.
- `wr_data` input 1: pixel value, 1 = lit.
- `clear` input 1: clears the write-side buffer in one cycle.
- `swap_req` input 1: single-cycle pulse requesting a buffer swap at the next frame boundary.
- `swap_done` output 1: one-cycle pulse when the swap happens.
- `frame_start` output 1: one-cycle pulse when the scan wraps from row 5 back to row 0.
- `row` output 6: active-high row drive; `row[y]` drives pixel row y.
- `col` output 6: active-low column sink; `col[x]` = 0 lights pixel x of the driven row.

## Operation
- **Storage.** Buffers are 36 bits wide (6 rows x 6 bits). `rst_n` low clears every buffer.
- **Writes.**
  - A write with `wr_x > 5` or `wr_y > 5` is ignored.
  - `clear` and `wr_en` in the same cycle: the clear applies first, then the write. The written pixel ends up equal to `wr_data`.
- **Scan FSM.** Two states, `BLANK` and `DRIVE`, plus a row index 0..5 and a dwell counter.
  - `BLANK`: `row` = 0 and `col` = 6'b111111. The FSM holds for `BLANK_CYCLES` cycles, then enters `DRIVE`.
  - `BLANK`→`DRIVE` edge: `row` = one-hot(row index) and `col` = ~buffer row contents, both latched on this edge. The latch is read-before-write: a write on the same edge is not shown until the next pass over that row.
  - `DRIVE`: holds for `ROW_CYCLES` cycles, then returns to `BLANK` with the row index incremented.
  - Row index 5 wraps to 0. `frame_start` pulses in the first `BLANK` cycle of the wrapped row 0.
- **Outputs.** `row` and `col` are registered and glitch-free. At most one `row` bit is ever high.
- **Swap.**
  - A `swap_req` pulse sets a pending flag.
  - On the wrap edge, if the flag is pending: front and back exchange, the new back buffer is loaded with a copy of the new front, `swap_done` pulses together with `frame_start`, and the flag clears.
  - A `swap_req` arriving on the wrap edge itself is not taken at that boundary; it stays pending for the next frame.
  - Multiple requests within one frame collapse into one swap.

## Timing
- Reset values:
  - `row` = 0, `col` = 6'b111111, `swap_done` = 0, `frame_start` = 0.
  - FSM in `BLANK`, row index 0, dwell counter 0, swap flag clear.
- Row period is `BLANK_CYCLES + ROW_CYCLES`. Frame period is 6 x (`BLANK_CYCLES + ROW_CYCLES`).
- Scan timing after `rst_n` releases:
  - Cycle 0 is the first `BLANK` cycle of row 0.
  - Row 0 drives from cycle `BLANK_CYCLES` onward.
  - The first `frame_start` occurs at cycle 6 x (`BLANK_CYCLES + ROW_CYCLES`). No frame_start pulse is generated for the frame that begins at reset release.
- Write-to-display latency: visible from the next `BLANK`→`DRIVE` edge of that row (single buffer), or after the next swap (double buffer).
- Reset asserted mid-row: the outputs go to their off values immediately and asynchronously; any pending swap is lost.

## Configuration
- `LED_SCAN_DOUBLE_BUFFER_EN` defined:
  - Two buffers; writes and `clear` go to the back buffer; the scan reads the front buffer.
  - Swap behaves as described under Operation.
- `LED_SCAN_DOUBLE_BUFFER_EN` undefined:
  - A single buffer is both written and scanned.
  - `swap_req` is ignored and `swap_done` is tied to 0.
  - `frame_start` is unchanged.

## Test plan
All scenarios use `ROW_CYCLES=4`, `BLANK_CYCLES=2`, giving a 36-cycle frame.
- **Reset scan:** release reset with an empty buffer → `row` 0 for cycles 0-1; `row`=000001 and `col`=111111 for cycles 2-5; `row`=000010 from cycle 8; `frame_start` high only in cycle 36.
- **Single-buffer write:** write (x=3,y=0,1) and (x=5,y=5,1) before cycle 2 → `col`=110111 while `row`=000001; `col`=011111 while `row`=100000. Writes with x=6 or y=7 leave every `col` value at 111111.
- **Read-before-write:** write (x=0,y=1,1) exactly on the row-1 latch edge (cycle 8) → row 1 shows `col`=111111 this frame and 111110 next frame.
- **Clear plus write:** lit buffer, then `clear` and write (x=2,y=2,1) in the same cycle → the next frame shows only `col`=111011 on `row`=000100.
- **Double buffer:** write (x=1,y=4,1) then pulse `swap_req` at cycle 10 → no change in frame 0; `swap_done` and `frame_start` both high at cycle 36; `row`=010000 shows `col`=111101 in frame 1. A second `swap_req` at cycle 36 swaps at cycle 72.
- **Reset mid-DRIVE:** assert `rst_n` low at cycle 4 → `row`=0 and `col`=111111 before the next clock edge; all pixels dark after release.
